strobe_decoder_3to8: RTL and testbench
======================================

# strobe_decoder_3to8

Registered 3-to-8 decoder with a valid/ready input handshake. Each accepted 3-bit code drives a one-hot strobe on `out_onehot` for a programmable number of cycles, followed by a programmable idle gap. It sits downstream of the 8-to-3 encoders and turns encoded channel indices back into timed per-channel select/enable strobes.

## Interface
- `HOLD_CYCLES`, default 2: cycles the one-hot strobe is held. Legal range 1..15.
- `GAP_CYCLES`, default 1: forced all-zero cycles after each strobe. Legal range 0..15.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort. Returns the block to IDLE.
- `in_valid` in 1: `in_code` and `in_en` are valid.
- `in_ready` out 1: the block can accept a code.
- `in_code` in 3: binary channel index, 0..7.
- `in_en` in 1: decoder enable. When 0, the accepted strobe is all-zero.
- `out_onehot` out 8: decoded strobe. Bit `in_code` is set when enabled.
- `out_valid` out 1: high while in DRIVE.
- `done` out 1: one-cycle pulse on the last DRIVE cycle.
- `xfer_count` out 8: count of accepted codes. Wraps 255→0.

## Operation
- FSM states are IDLE, DRIVE and GAP.
- `in_ready = (state==IDLE) && !flush`. This is the only combinational output.
- A transfer is accepted when `in_valid && in_ready` on a rising edge.
- On acceptance:
  - Latch `onehot = in_en ? (8'b1 << in_code) : 8'h00`.
  - Load the hold counter with `HOLD_CYCLES-1`.
  - Increment `xfer_count`.
  - Move to DRIVE.
- DRIVE:
  - `out_valid=1` and `out_onehot` = the latched value.
  - The counter decrements each cycle.
  - At counter==0, `done=1`. The next state is GAP with counter `GAP_CYCLES-1`, or IDLE if `GAP_CYCLES==0`.
- GAP:
  - `out_onehot=0` and `out_valid=0`.
  - At counter==0, go to IDLE.
- `in_code` and `in_en` are ignored outside the accepting edge. Changes to them during DRIVE have no effect.
- `flush`, from any state:
  - The next state is IDLE.
  - `out_onehot`, `out_valid` and `done` are 0 from the next cycle.
  - `xfer_count` is unchanged.
  - `flush` in IDLE with `in_valid=1` accepts nothing.
- Reset values: state IDLE, `out_onehot=8'h00`, `out_valid=0`, `done=0`, `xfer_count=0`, counter 0. `in_ready` is 1 during reset provided `flush=0`.
- Reset asserted mid-DRIVE clears all outputs immediately (asynchronously). No strobe resumes after reset is released.

## Timing
- Acceptance edge at the end of cycle T. DRIVE occupies cycles T+1..T+HOLD_CYCLES.
- GAP occupies the next `GAP_CYCLES` cycles. IDLE, with `in_ready=1`, follows.
- Minimum period between accepts is `HOLD_CYCLES+GAP_CYCLES+1` cycles. With the defaults this is 4.
- Output latency from acceptance to strobe is 1 cycle. `out_onehot`, `out_valid` and `done` are all registered.
- `done` coincides with cycle T+HOLD_CYCLES.

## Structure
- Package `decoder_pkg` holds:
  - `CODE_W=3`
  - `ONEHOT_W=8`
  - `CNT_W=4`
  - state enum `dec_state_t` {IDLE, DRIVE, GAP}
- Sub-module `decoder_3to8_comb`: purely combinational `in[2:0]`, `en` → `y[7:0]`. It is instantiated once, ahead of the output register.
- Parameter range checks are elaboration-time assertions.

## Test plan
- **Reset state:** assert `rst_n=0` mid-DRIVE of code 5 → `out_onehot` goes to 00 immediately. After release: `in_ready=1`, `xfer_count=0`, no residual strobe.
- **Basic strobe (defaults):** accept code 3, `en=1`. Required:
  - `out_onehot=8'h08` with `out_valid=1` for exactly 2 cycles, `done` on the 2nd.
  - Then 1 GAP cycle of 00.
  - `in_ready` returns on the 4th cycle after acceptance.
- **Sweep and wrap:** accept codes 0..7 back-to-back with `in_valid` held high. Required:
  - Strobes 01, 02, 04, …, 80 in order, one accept every 4 cycles, `xfer_count=8`.
  - After 256 accepts total, `xfer_count=0`.
- **Enable low:** accept code 6 with `en=0` → `out_onehot=00` but `out_valid=1` for HOLD cycles, `done` pulses, `xfer_count` increments.
- **Flush:**
  - `flush` on the 1st DRIVE cycle of code 7 → the next cycle is IDLE, `out_onehot=00`, `done` never pulses.
  - `flush` in IDLE together with `in_valid` → no accept, `xfer_count` unchanged.
- **Parameter corners:**
  - HOLD=1, GAP=0, code 1 → `out_onehot=02` for 1 cycle, `done` same cycle, accepts every 2 cycles.
  - HOLD=15, GAP=15 → 15-cycle strobe followed by a 15-cycle gap.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared definitions for the 3-to-8 strobe decoder.
//   CODE_W   : width of the binary channel index
//   ONEHOT_W : width of the decoded strobe
//   CNT_W    : width of the hold/gap cycle counter
//   XFER_W   : width of the accepted-transfer counter
//   dec_state_t : IDLE (ready for a code), DRIVE (strobe held), GAP (forced zero)
package decoder_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 8;
  localparam int CNT_W    = 4;
  localparam int XFER_W   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_t;

endpackage

// File: rtl/strobe_decoder_3to8_if.sv
// Handshake and strobe bus of the 3-to-8 strobe decoder.
//   in_valid / in_ready : code handshake (master -> slave / slave -> master)
//   in_code, in_en      : channel index and enable, sampled on the accepting edge
//   out_onehot          : decoded strobe
//   out_valid, done     : strobe qualifier and last-cycle pulse
//   xfer_count          : number of accepted codes (wrapping)
interface strobe_decoder_3to8_if;
  import decoder_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                in_en;
  logic [ONEHOT_W-1:0] out_onehot;
  logic                out_valid;
  logic                done;
  logic [XFER_W-1:0]   xfer_count;

  modport master (
    output in_valid, in_code, in_en,
    input  in_ready, out_onehot, out_valid, done, xfer_count
  );

  modport slave (
    input  in_valid, in_code, in_en,
    output in_ready, out_onehot, out_valid, done, xfer_count
  );

endinterface

// File: rtl/decoder_3to8_comb.sv
// Purely combinational 3-to-8 decoder.
//   in : binary channel index
//   en : enable; when low the result is all-zero
//   y  : one-hot result (bit `in` set when enabled)
module decoder_3to8_comb
  import decoder_pkg::*;
(
  input  logic [CODE_W-1:0]   in,
  input  logic                en,
  output logic [ONEHOT_W-1:0] y
);

  localparam logic [ONEHOT_W-1:0] ONE = {{(ONEHOT_W-1){1'b0}}, 1'b1};

  // Shift a single set bit into the selected channel position.
  always_comb begin
    y = {ONEHOT_W{1'b0}};
    if (en) begin
      y = ONE << in;
    end else begin
      y = {ONEHOT_W{1'b0}};
    end
  end

endmodule

// File: rtl/strobe_decoder_3to8.sv
// Registered 3-to-8 strobe decoder with a valid/ready input handshake.
// Each accepted code produces a one-hot strobe held for HOLD_CYCLES cycles,
// followed by GAP_CYCLES forced all-zero cycles before the next code can be
// accepted.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   flush : synchronous abort back to IDLE (transfer counter preserved)
//   bus   : slave side of strobe_decoder_3to8_if
module strobe_decoder_3to8
  import decoder_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int GAP_CYCLES  = 1
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  strobe_decoder_3to8_if.slave  bus
);

  if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 15)) begin : g_bad_hold
    $error("HOLD_CYCLES must be within 1..15");
  end
  if ((GAP_CYCLES < 0) || (GAP_CYCLES > 15)) begin : g_bad_gap
    $error("GAP_CYCLES must be within 0..15");
  end

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam bit               HAS_GAP   = (GAP_CYCLES > 0);
  // Only used when HAS_GAP, so the GAP_CYCLES==0 underflow never matters.
  localparam logic [CNT_W-1:0] GAP_LOAD  = HAS_GAP ? CNT_W'(GAP_CYCLES - 1) : CNT_ZERO;
  localparam logic [ONEHOT_W-1:0] STROBE_ZERO = {ONEHOT_W{1'b0}};
  localparam logic [XFER_W-1:0]   XFER_ONE    = {{(XFER_W-1){1'b0}}, 1'b1};

  dec_state_t          state_r,      next_state_s;
  logic [CNT_W-1:0]    cnt_r,        next_cnt_s;
  logic [ONEHOT_W-1:0] strobe_r,     next_strobe_s;
  logic [XFER_W-1:0]   xfer_count_r, next_xfer_count_s;
  logic                valid_r,      next_valid_s;
  logic                done_r,       next_done_s;
  logic [ONEHOT_W-1:0] dec_y_s;
  logic                ready_s;

  decoder_3to8_comb u_dec (
    .in (bus.in_code),
    .en (bus.in_en),
    .y  (dec_y_s)
  );

  assign ready_s        = (state_r == IDLE) && !flush;
  assign bus.in_ready   = ready_s;
  assign bus.out_onehot = strobe_r;
  assign bus.out_valid  = valid_r;
  assign bus.done       = done_r;
  assign bus.xfer_count = xfer_count_r;

  // Next-state, counter and registered-output computation.
  always_comb begin
    next_state_s      = state_r;
    next_cnt_s        = cnt_r;
    next_strobe_s     = strobe_r;
    next_xfer_count_s = xfer_count_r;

    if (flush) begin
      next_state_s  = IDLE;
      next_cnt_s    = CNT_ZERO;
      next_strobe_s = STROBE_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            // ready_s is true here since flush is low and state is IDLE.
            next_state_s      = DRIVE;
            next_cnt_s        = HOLD_LOAD;
            next_strobe_s     = dec_y_s;
            next_xfer_count_s = xfer_count_r + XFER_ONE;
          end else begin
            next_strobe_s = STROBE_ZERO;
          end
        end
        DRIVE: begin
          if (cnt_r == CNT_ZERO) begin
            next_strobe_s = STROBE_ZERO;
            if (HAS_GAP) begin
              next_state_s = GAP;
              next_cnt_s   = GAP_LOAD;
            end else begin
              next_state_s = IDLE;
              next_cnt_s   = CNT_ZERO;
            end
          end else begin
            next_cnt_s = cnt_r - CNT_ONE;
          end
        end
        GAP: begin
          next_strobe_s = STROBE_ZERO;
          if (cnt_r == CNT_ZERO) begin
            next_state_s = IDLE;
          end else begin
            next_cnt_s = cnt_r - CNT_ONE;
          end
        end
        default: begin
          next_state_s  = IDLE;
          next_cnt_s    = CNT_ZERO;
          next_strobe_s = STROBE_ZERO;
        end
      endcase
    end

    // Outputs are registered, so derive them from where the FSM is heading:
    // done marks the DRIVE cycle whose counter value is zero.
    next_valid_s = (next_state_s == DRIVE);
    if (next_valid_s && (next_cnt_s == CNT_ZERO)) begin
      next_done_s = 1'b1;
    end else begin
      next_done_s = 1'b0;
    end
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      strobe_r     <= STROBE_ZERO;
      xfer_count_r <= {XFER_W{1'b0}};
      valid_r      <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cnt_r        <= next_cnt_s;
      strobe_r     <= next_strobe_s;
      xfer_count_r <= next_xfer_count_s;
      valid_r      <= next_valid_s;
      done_r       <= next_done_s;
    end
  end

endmodule

// File: tb/tb_strobe_decoder_3to8.sv
// Bench for strobe_decoder_3to8: three instances (defaults, HOLD=1/GAP=0,
// HOLD=15/GAP=15) share one directed stimulus; an elapsed-time model per
// instance is compared on every falling edge, plus hand-computed spot checks.
module tb_strobe_decoder_3to8;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_en;

  int n_checks = 0;
  int n_err    = 0;
  int cyc_n    = 0;

  strobe_decoder_3to8_if bus0 ();
  strobe_decoder_3to8_if bus1 ();
  strobe_decoder_3to8_if bus2 ();

  assign bus0.in_valid = in_valid; assign bus0.in_code = in_code; assign bus0.in_en = in_en;
  assign bus1.in_valid = in_valid; assign bus1.in_code = in_code; assign bus1.in_en = in_en;
  assign bus2.in_valid = in_valid; assign bus2.in_code = in_code; assign bus2.in_en = in_en;

  strobe_decoder_3to8 #(.HOLD_CYCLES(2),  .GAP_CYCLES(1))
    dut0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus0));
  strobe_decoder_3to8 #(.HOLD_CYCLES(1),  .GAP_CYCLES(0))
    dut1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus1));
  strobe_decoder_3to8 #(.HOLD_CYCLES(15), .GAP_CYCLES(15))
    dut2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2));

  logic [7:0] oh_a [3];
  logic       ov_a [3];
  logic       dn_a [3];
  logic       rd_a [3];
  logic [7:0] xc_a [3];
  assign oh_a[0] = bus0.out_onehot; assign ov_a[0] = bus0.out_valid; assign dn_a[0] = bus0.done;
  assign rd_a[0] = bus0.in_ready;   assign xc_a[0] = bus0.xfer_count;
  assign oh_a[1] = bus1.out_onehot; assign ov_a[1] = bus1.out_valid; assign dn_a[1] = bus1.done;
  assign rd_a[1] = bus1.in_ready;   assign xc_a[1] = bus1.xfer_count;
  assign oh_a[2] = bus2.out_onehot; assign ov_a[2] = bus2.out_valid; assign dn_a[2] = bus2.done;
  assign rd_a[2] = bus2.in_ready;   assign xc_a[2] = bus2.xfer_count;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // Model: per instance, number of cycles elapsed since the accepting edge
  // (0 = idle). Cycles 1..HOLD are DRIVE, HOLD+1..HOLD+GAP are GAP.
  int         hold_p [3] = '{2, 1, 15};
  int         gap_p  [3] = '{1, 0, 15};
  int         k_m    [3];
  logic [7:0] oh_m   [3];
  logic [7:0] cnt_m  [3];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        k_m[i]   <= 0;
        oh_m[i]  <= 8'h00;
        cnt_m[i] <= 8'h00;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (flush) begin
          k_m[i] <= 0;
        end else if (k_m[i] == 0) begin
          if (in_valid) begin
            k_m[i]   <= 1;
            oh_m[i]  <= in_en ? (8'h01 << in_code) : 8'h00;
            cnt_m[i] <= cnt_m[i] + 8'd1;
          end
        end else if (k_m[i] >= hold_p[i] + gap_p[i]) begin
          k_m[i] <= 0;
        end else begin
          k_m[i] <= k_m[i] + 1;
        end
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("onehot[%0d]", i), int'(oh_a[i]),
          ((k_m[i] >= 1) && (k_m[i] <= hold_p[i])) ? int'(oh_m[i]) : 0);
      chk($sformatf("out_valid[%0d]", i), int'(ov_a[i]),
          ((k_m[i] >= 1) && (k_m[i] <= hold_p[i])) ? 1 : 0);
      chk($sformatf("done[%0d]", i), int'(dn_a[i]), (k_m[i] == hold_p[i]) ? 1 : 0);
      chk($sformatf("in_ready[%0d]", i), int'(rd_a[i]), ((k_m[i] == 0) && !flush) ? 1 : 0);
      chk($sformatf("xfer_count[%0d]", i), int'(xc_a[i]), int'(cnt_m[i]));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (!(bus0.in_ready && bus1.in_ready && bus2.in_ready) && (g < 100)) begin
      cyc();
      g++;
    end
    chk("wait_idle_bound", (g < 100) ? 1 : 0, 1);
  endtask

  task automatic wait_ready0();
    int g = 0;
    while (!bus0.in_ready && (g < 50)) begin
      cyc();
      g++;
    end
    chk("wait_ready0_bound", (g < 50) ? 1 : 0, 1);
  endtask

  initial begin
    int         t_prev;
    int         nv;
    int         first_rdy;
    logic [7:0] exp8;
    logic [7:0] c1;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_code = 3'd0; in_en = 1'b1;
    cyc(); cyc();
    chk("reset_ready", int'(bus0.in_ready), 1);
    chk("reset_count", int'(bus0.xfer_count), 0);
    chk("reset_onehot", int'(bus0.out_onehot), 0);
    rst_n = 1'b1;
    cyc();

    // Basic strobe, code 3, defaults.
    in_valid = 1'b1; in_code = 3'd3; in_en = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("basic_c1_onehot", int'(bus0.out_onehot), 8);
    chk("basic_c1_valid", int'(bus0.out_valid), 1);
    chk("basic_c1_done", int'(bus0.done), 0);
    chk("hold1_onehot", int'(bus1.out_onehot), 8);
    chk("hold1_done", int'(bus1.done), 1);
    cyc();
    chk("basic_c2_onehot", int'(bus0.out_onehot), 8);
    chk("basic_c2_done", int'(bus0.done), 1);
    cyc();
    chk("basic_gap_onehot", int'(bus0.out_onehot), 0);
    chk("basic_gap_valid", int'(bus0.out_valid), 0);
    chk("basic_gap_ready", int'(bus0.in_ready), 0);
    cyc();
    chk("basic_ready_back", int'(bus0.in_ready), 1);
    chk("basic_count", int'(bus0.xfer_count), 1);

    // Sweep codes 0..7 with in_valid held high.
    wait_idle();
    in_valid = 1'b1;
    t_prev = 0;
    for (int idx = 0; idx < 8; idx++) begin
      in_code = 3'(idx);
      wait_ready0();
      cyc();
      exp8 = 8'h01 << idx;
      chk($sformatf("sweep_onehot_%0d", idx), int'(bus0.out_onehot), int'(exp8));
      if (idx > 0) chk($sformatf("sweep_period_%0d", idx), cyc_n - t_prev, 4);
      t_prev = cyc_n;
    end
    in_valid = 1'b0;
    chk("sweep_count", int'(bus0.xfer_count), 9);

    // Enable low: zero strobe but full handshake timing.
    wait_idle();
    in_valid = 1'b1; in_code = 3'd6; in_en = 1'b0;
    cyc();
    in_valid = 1'b0; in_en = 1'b1;
    chk("en0_onehot", int'(bus0.out_onehot), 0);
    chk("en0_valid", int'(bus0.out_valid), 1);
    cyc();
    chk("en0_done", int'(bus0.done), 1);
    chk("en0_count", int'(bus0.xfer_count), 10);

    // Flush on the first DRIVE cycle of code 7.
    wait_idle();
    in_valid = 1'b1; in_code = 3'd7;
    cyc();
    in_valid = 1'b0;
    chk("flush_pre_onehot", int'(bus0.out_onehot), 128);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    #1;
    chk("flush_onehot", int'(bus0.out_onehot), 0);
    chk("flush_valid", int'(bus0.out_valid), 0);
    chk("flush_done", int'(bus0.done), 0);
    chk("flush_ready", int'(bus0.in_ready), 1);
    cyc();
    chk("flush_no_done", int'(bus0.done), 0);

    // Flush in IDLE together with in_valid: nothing accepted.
    wait_idle();
    flush = 1'b1; in_valid = 1'b1;
    cyc(); cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_idle_count", int'(bus0.xfer_count), 11);
    chk("flush_idle_valid", int'(bus0.out_valid), 0);

    // HOLD=1, GAP=0: accepts every 2 cycles.
    wait_idle();
    c1 = bus1.xfer_count;
    in_valid = 1'b1; in_code = 3'd1;
    cyc();
    chk("h1_onehot", int'(bus1.out_onehot), 2);
    chk("h1_done", int'(bus1.done), 1);
    cyc();
    chk("h1_ready", int'(bus1.in_ready), 1);
    chk("h1_idle_onehot", int'(bus1.out_onehot), 0);
    cyc();
    in_valid = 1'b0;
    chk("h1_two_accepts", int'(bus1.xfer_count), int'(c1 + 8'd2));

    // HOLD=15, GAP=15: 15-cycle strobe then 15-cycle gap.
    wait_idle();
    in_valid = 1'b1; in_code = 3'd2;
    cyc();
    in_valid = 1'b0;
    nv = 0; first_rdy = 0;
    for (int j = 1; j <= 40; j++) begin
      if (bus2.out_valid) nv++;
      if (bus2.in_ready && (first_rdy == 0)) first_rdy = j;
      cyc();
    end
    chk("h15_valid_cycles", nv, 15);
    chk("h15_ready_cycle", first_rdy, 31);
    chk("pre_wrap_count", int'(bus0.xfer_count), 13);

    // Run instance 0 up to 256 accepts so its counter wraps.
    wait_idle();
    in_valid = 1'b1; in_code = 3'd4;
    for (int n = 14; n <= 256; n++) begin
      wait_ready0();
      if (n == 256) chk("count_255", int'(bus0.xfer_count), 255);
      cyc();
    end
    in_valid = 1'b0;
    chk("count_wrap", int'(bus0.xfer_count), 0);

    // Reset asserted mid-DRIVE of code 5.
    wait_idle();
    in_valid = 1'b1; in_code = 3'd5;
    cyc();
    in_valid = 1'b0;
    chk("rst_pre_onehot", int'(bus0.out_onehot), 32);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_onehot", int'(bus0.out_onehot), 0);
    chk("rst_async_valid", int'(bus0.out_valid), 0);
    cyc();
    chk("rst_ready", int'(bus0.in_ready), 1);
    chk("rst_count", int'(bus0.xfer_count), 0);
    rst_n = 1'b1;
    for (int j = 0; j < 5; j++) cyc();
    chk("rst_no_residual", int'(bus0.out_onehot), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
